mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core, replacing the single-cycle decoder.
- Sequences each instruction through IF/ID/EX/MEM/WB and drives datapath enables and mux selects for a shared instruction/data memory with a ready handshake.
- Counts retired instructions for the testbench and halts on illegal opcodes.
- Supported: addu, subu, jr, ori, lui, lw, sw, beq, j, jal. The all-zero word executes as nop (R-type, funct 0x00).

Parameters:
- CNT_W, 32, width of instr_cnt.
- HALT_ON_UNKNOWN, 1.
  - 1: an unknown opcode/funct enters the sticky HALT state.
  - 0: an unknown opcode/funct retires as nop.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- instr  in  32  memory read data, captured at the end of IF.
- mem_ready  in  1  memory access completes this cycle.
- zero  in  1  ALU equality flag, valid in EX.
- im_re  out  1  instruction fetch request.
- ir_we  out  1  IR load.
- pc_we  out  1  PC load.
- npc_sel  out  2  next PC: 0 pc+4, 1 branch, 2 jump target, 3 rs.
- reg_we  out  1  GRF write.
- reg_dst  out  2  write address: 0 rt, 1 rd, 2 $31.
- wd_sel  out  2  write data: 0 ALU, 1 memory, 2 pc+4.
- alu_op  out  2  0 ADD, 1 SUB, 2 OR, 3 LUI.
- alu_src_b  out  1  0 rt, 1 extended immediate.
- ext_op  out  1  0 zero-extend, 1 sign-extend.
- dm_re  out  1  data read request.
- dm_we  out  1  data write request.
- state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7.
- retire  out  1  one-cycle pulse on the last cycle of an instruction.
- instr_cnt  out  CNT_W  retired-instruction count.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset: while reset=0, state=IF, instr_cnt=0 and the latched op/funct are cleared.
  - All write enables (pc_we, ir_we, reg_we, dm_we) and retire are forced to 0, combinationally gated by reset.
  - Every other output is 0.
- Output timing: outputs are Moore functions of state plus the latched op/funct. The FSM latches op=instr[31:26] and funct=instr[5:0] on the IF exit edge.
- IF:
  - im_re=1.
  - When mem_ready=1: ir_we=1, pc_we=1, npc_sel=0, then go to ID.
  - Otherwise hold IF with all enables 0.
- ID transitions:
  - addu/subu/ori/lui/lw/sw/beq/jr/j go to EX.
  - jal goes to WB.
  - nop retires and goes to IF.
  - Unknown: HALT if HALT_ON_UNKNOWN=1, else retire as nop and go to IF.
- EX:
  - addu/subu/ori/lui: set ALU controls, then WB.
  - lw/sw: ADD with sign-extended immediate, then MEM.
  - beq: SUB, pc_we=zero, npc_sel=1, retire, then IF.
  - jr: pc_we=1, npc_sel=3, retire, then IF.
  - j: pc_we=1, npc_sel=2, retire, then IF.
- MEM:
  - lw: dm_re=1; advance to WB on mem_ready.
  - sw: dm_we=1; on mem_ready retire and go to IF.
  - While mem_ready=0: hold MEM with address/enables stable; dm_we stays asserted only while waiting.
- WB: reg_we=1, retire, then IF. Selects:
  - addu/subu: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
  - jal: reg_dst=2, wd_sel=2, plus pc_we=1, npc_sel=2.
- ALU controls are held from EX through MEM/WB. alu_op/ext_op per instruction:
  - addu: ADD.
  - subu: SUB.
  - ori: OR, ext_op=0.
  - lui: LUI.
  - lw/sw: ADD, ext_op=1.
  - beq: SUB.
- Cycle counts with mem_ready always 1:
  - R-type, ori, lui: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jr, jal: 3.
  - nop: 2.
- Counter: instr_cnt increments on each retire and wraps modulo 2^CNT_W.
- HALT: sticky; all enables 0, halted=1, exit only via reset.
- Reset mid-operation (any state, including a memory wait): state goes to IF immediately and no partial write is issued.

Decomposition:
- Shared package mc_pkg holds:
  - State encodings.
  - Opcode/funct constants (R=0x00, ori=0x0D, lui=0x0F, lw=0x23, sw=0x2B, beq=0x04, j=0x02, jal=0x03; addu=0x21, subu=0x23, jr=0x08).
  - alu_op, npc_sel, reg_dst and wd_sel encodings.
- One sub-module mc_decode: combinational op/funct to instruction-class one-hots, instantiated inside mc_ctrl.

Test Plan:
- 0x34011234 (ori), mem_ready=1:
  - state sequence 0,1,2,4,0.
  - alu_op=2, ext_op=0, alu_src_b=1; reg_we=1 only in WB.
  - retire in cycle 4, instr_cnt=1.
- lw 0x8C220004 with mem_ready low for 3 cycles in MEM:
  - MEM held 4 cycles with dm_re=1 throughout, then WB with wd_sel=1.
  - Total 8 cycles.
- beq 0x10220003 with zero=1: pc_we=1 and npc_sel=1 in EX. Rerun with zero=0: pc_we=0. Both retire in 3 cycles.
- jal 0x0C000010:
  - states 0,1,4.
  - In WB: reg_dst=2, wd_sel=2, pc_we=1, npc_sel=2, reg_we=1.
- Opcode 0x3F with HALT_ON_UNKNOWN=1:
  - state=7, halted=1, im_re=0 for 20 cycles, instr_cnt unchanged.
  - Reset pulse returns to IF with count 0.
- reset driven low during a sw MEM wait:
  - state=0 asynchronously, dm_we=0 in the same cycle, instr_cnt=0.
  - After release, fetch resumes with im_re=1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcode/funct
// values, datapath select encodings and the decoded instruction-class bundle.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  // Next-PC source
  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_JMP = 2'd2;
  localparam logic [1:0] NPC_RS  = 2'd3;

  // Register-file write address source
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  // Register-file write data source
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  // One-hot instruction class; exactly one field is set for any op/funct.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic nop;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic unknown;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational decode of the latched op/funct into instruction-class one-hots.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  // Anything not in the supported set falls through to the unknown class.
  always_comb begin
    cls = '0;
    case (op)
      OP_R: begin
        case (funct)
          FN_NOP:  cls.nop  = 1'b1;
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls.unknown = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: walks each instruction through IF/ID/EX/MEM/WB,
// drives datapath enables and selects, counts retirements, halts on illegal ops.
// Handshake: a memory access (fetch in IF, load/store in MEM) is presented and
// held stable until the cycle in which mem_ready=1; that cycle completes it.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_UNKNOWN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             im_re,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [1:0]       alu_op,
  output logic             alu_src_b,
  output logic             ext_op,
  output logic             dm_re,
  output logic             dm_we,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             halted
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, funct_q;
  logic [CNT_W-1:0] cnt_q;
  iclass_t          cls;

  // Only op and funct drive control; the remaining fields belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  mc_decode u_decode (
    .op    (op_q),
    .funct (funct_q),
    .cls   (cls)
  );

  // State register; reset returns to IF immediately, even mid memory wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Latch op/funct on the edge that completes the instruction fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      funct_q <= '0;
    end else if (state_q == S_IF && mem_ready) begin
      op_q    <= instr[31:26];
      funct_q <= instr[5:0];
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Next-state sequencing per instruction class.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (cls.jal)          state_d = S_WB;
        else if (cls.nop)     state_d = S_IF;
        else if (cls.unknown) state_d = HALT_ON_UNKNOWN ? S_HALT : S_IF;
        else                  state_d = S_EX;
      end
      S_EX: begin
        if (cls.lw || cls.sw)                             state_d = S_MEM;
        else if (cls.addu || cls.subu || cls.ori || cls.lui) state_d = S_WB;
        else                                              state_d = S_IF;
      end
      S_MEM: if (mem_ready) state_d = cls.lw ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Moore outputs from state and latched class; everything forced low in reset.
  always_comb begin
    im_re     = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    npc_sel   = NPC_PC4;
    reg_we    = 1'b0;
    reg_dst   = DST_RT;
    wd_sel    = WD_ALU;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    dm_re     = 1'b0;
    dm_we     = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    if (reset) begin
      // ALU controls stay valid from EX through MEM/WB so the address/result holds.
      if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
        if (cls.subu || cls.beq) alu_op = ALU_SUB;
        else if (cls.ori)        alu_op = ALU_OR;
        else if (cls.lui)        alu_op = ALU_LUI;
        alu_src_b = cls.ori || cls.lui || cls.lw || cls.sw;
        ext_op    = cls.lw || cls.sw;
      end
      case (state_q)
        S_IF: begin
          im_re = 1'b1;
          ir_we = mem_ready;
          pc_we = mem_ready;
        end
        S_ID: retire = cls.nop || (cls.unknown && !HALT_ON_UNKNOWN);
        S_EX: begin
          if (cls.beq) begin
            pc_we   = zero;
            npc_sel = NPC_BR;
            retire  = 1'b1;
          end else if (cls.jr) begin
            pc_we   = 1'b1;
            npc_sel = NPC_RS;
            retire  = 1'b1;
          end else if (cls.j) begin
            pc_we   = 1'b1;
            npc_sel = NPC_JMP;
            retire  = 1'b1;
          end
        end
        S_MEM: begin
          dm_re  = cls.lw;
          dm_we  = cls.sw;
          retire = cls.sw && mem_ready;
        end
        S_WB: begin
          reg_we = 1'b1;
          retire = 1'b1;
          if (cls.addu || cls.subu) begin
            reg_dst = DST_RD;
          end else if (cls.lw) begin
            wd_sel = WD_MEM;
          end else if (cls.jal) begin
            reg_dst = DST_RA;
            wd_sel  = WD_PC4;
            pc_we   = 1'b1;
            npc_sel = NPC_JMP;
          end
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each driven cycle pushes a hand-computed expected
// output vector; a negedge monitor pops and compares against the DUT outputs.
module tb_mc_ctrl;

  localparam int W = 29;

  // Observed vector layout (msb first)
  typedef struct packed {
    logic [2:0] st;
    logic       im_re, ir_we, pc_we;
    logic [1:0] npc;
    logic       reg_we;
    logic [1:0] rdst, wds, aop;
    logic       srcb, ext, dre, dwe, ret, hlt;
    logic [7:0] cnt;
  } obs_t;

  localparam logic [31:0] I_ORI  = 32'h34011234;
  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_SUBU = 32'h00221823;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220008;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_J    = 32'h08000020;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_NOP  = 32'h00000000;
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        im_re, ir_we, pc_we, reg_we, alu_src_b, ext_op, dm_re, dm_we, retire, halted;
  logic [1:0]  npc_sel, reg_dst, wd_sel, alu_op;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           failures;
  obs_t         act;

  mc_ctrl #(.CNT_W(32), .HALT_ON_UNKNOWN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .mem_ready (mem_ready),
    .zero      (zero),
    .im_re     (im_re),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .npc_sel   (npc_sel),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .ext_op    (ext_op),
    .dm_re     (dm_re),
    .dm_we     (dm_we),
    .state     (state),
    .retire    (retire),
    .instr_cnt (instr_cnt),
    .halted    (halted)
  );

  assign act = {state, im_re, ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel, alu_op,
                alu_src_b, ext_op, dm_re, dm_we, retire, halted, instr_cnt[7:0]};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- expected-vector builder ----------------
  function automatic logic [W-1:0] mk(
    input logic [2:0] st, input logic im, input logic irw, input logic pcw,
    input logic [1:0] npc, input logic rw, input logic [1:0] rdst, input logic [1:0] wds,
    input logic [1:0] aop, input logic srcb, input logic ext, input logic dre,
    input logic dwe, input logic ret, input logic hlt, input logic [7:0] cnt);
    obs_t o;
    o = {st, im, irw, pcw, npc, rw, rdst, wds, aop, srcb, ext, dre, dwe, ret, hlt, cnt};
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic [31:0] ins, input logic rdy, input logic z,
                     input logic [W-1:0] e, input string nm);
    reset     = r;
    instr     = ins;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // IF completing immediately, then a non-retiring ID cycle.
  task automatic fetch(input logic [31:0] ins, input logic [7:0] cnt, input string nm);
    cyc(1'b1, ins, 1'b1, 1'b0, mk(0,1,1,1,0,0,0,0,0,0,0,0,0,0,0,cnt), {nm, "_if"});
    cyc(1'b1, ins, 1'b1, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,cnt), {nm, "_id"});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    instr = I_NOP;
    mem_ready = 1'b0;
    zero = 1'b0;
    @(posedge clk);
    #1;

    // Reset state: everything low, count 0
    cyc(0, I_ORI, 1, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "rst_a");
    cyc(0, I_ORI, 1, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "rst_b");

    // ori: IF ID EX WB
    fetch(I_ORI, 0, "ori");
    cyc(1, I_ORI, 1, 0, mk(2,0,0,0,0,0,0,0,2,1,0,0,0,0,0,0), "ori_ex");
    cyc(1, I_ORI, 1, 0, mk(4,0,0,0,0,1,0,0,2,1,0,0,0,1,0,0), "ori_wb");

    // addu
    fetch(I_ADDU, 1, "addu");
    cyc(1, I_ADDU, 1, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1), "addu_ex");
    cyc(1, I_ADDU, 1, 0, mk(4,0,0,0,0,1,1,0,0,0,0,0,0,1,0,1), "addu_wb");

    // subu
    fetch(I_SUBU, 2, "subu");
    cyc(1, I_SUBU, 1, 0, mk(2,0,0,0,0,0,0,0,1,0,0,0,0,0,0,2), "subu_ex");
    cyc(1, I_SUBU, 1, 0, mk(4,0,0,0,0,1,1,0,1,0,0,0,0,1,0,2), "subu_wb");

    // lw with three wait cycles in MEM
    fetch(I_LW, 3, "lw");
    cyc(1, I_LW, 1, 0, mk(2,0,0,0,0,0,0,0,0,1,1,0,0,0,0,3), "lw_ex");
    for (int i = 0; i < 3; i++)
      cyc(1, I_LW, 0, 0, mk(3,0,0,0,0,0,0,0,0,1,1,1,0,0,0,3), "lw_mem_wait");
    cyc(1, I_LW, 1, 0, mk(3,0,0,0,0,0,0,0,0,1,1,1,0,0,0,3), "lw_mem_done");
    cyc(1, I_LW, 1, 0, mk(4,0,0,0,0,1,0,1,0,1,1,0,0,1,0,3), "lw_wb");

    // beq taken / not taken
    fetch(I_BEQ, 4, "beq1");
    cyc(1, I_BEQ, 1, 1, mk(2,0,0,1,1,0,0,0,1,0,0,0,0,1,0,4), "beq1_ex");
    fetch(I_BEQ, 5, "beq0");
    cyc(1, I_BEQ, 1, 0, mk(2,0,0,0,1,0,0,0,1,0,0,0,0,1,0,5), "beq0_ex");

    // jal: IF ID WB
    fetch(I_JAL, 6, "jal");
    cyc(1, I_JAL, 1, 0, mk(4,0,0,1,2,1,2,2,0,0,0,0,0,1,0,6), "jal_wb");

    // j and jr
    fetch(I_J, 7, "j");
    cyc(1, I_J, 1, 0, mk(2,0,0,1,2,0,0,0,0,0,0,0,0,1,0,7), "j_ex");
    fetch(I_JR, 8, "jr");
    cyc(1, I_JR, 1, 0, mk(2,0,0,1,3,0,0,0,0,0,0,0,0,1,0,8), "jr_ex");

    // nop: retires from ID
    cyc(1, I_NOP, 1, 0, mk(0,1,1,1,0,0,0,0,0,0,0,0,0,0,0,9), "nop_if");
    cyc(1, I_NOP, 1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1,0,9), "nop_id");

    // sw interrupted by reset while waiting in MEM
    fetch(I_SW, 10, "sw");
    cyc(1, I_SW, 1, 0, mk(2,0,0,0,0,0,0,0,0,1,1,0,0,0,0,10), "sw_ex");
    cyc(1, I_SW, 0, 0, mk(3,0,0,0,0,0,0,0,0,1,1,0,1,0,0,10), "sw_mem_wait");
    cyc(0, I_SW, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "sw_rst_a");
    cyc(0, I_SW, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "sw_rst_b");
    cyc(1, I_NOP, 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "post_rst_if");

    // one nop so the halt check sees a nonzero count
    cyc(1, I_NOP, 1, 0, mk(0,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0), "nop2_if");
    cyc(1, I_NOP, 1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0), "nop2_id");

    // illegal opcode 0x3F: sticky HALT
    fetch(I_ILL, 1, "ill");
    for (int i = 0; i < 20; i++)
      cyc(1, I_ILL, 1, 0, mk(7,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1), "halt");
    cyc(0, I_ILL, 1, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "halt_rst");
    cyc(1, I_ORI, 1, 0, mk(0,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0), "halt_exit_if");

    // every pushed vector must have been consumed
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
